// File: rtl/instr_fetch_pkg.sv
// rv32i shared package: opcodes, immediate-type codes, fetch states.
// Imported by the fetch stage, its interface and the immediate predecoder.
package rv32i_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read handshake between fetch stage and imem.
// master = fetch stage, slave = memory.
interface instr_fetch_if;
  import rv32i_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );

endinterface

// File: rtl/instr_fetch_imm_predecode.sv
// Opcode to immediate-type select, registered alongside the IR
// so the immediate generator no longer waits on the decoder.
module imm_predecode
  import rv32i_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_ctrl
);

  always_comb begin
    o_imm_ctrl = IMM_I;
    unique case (1'b1)
      (i_opcode == OP_STORE):  o_imm_ctrl = IMM_S;
      (i_opcode == OP_LUI),
      (i_opcode == OP_AUIPC):  o_imm_ctrl = IMM_U;
      (i_opcode == OP_BRANCH): o_imm_ctrl = IMM_B;
      (i_opcode == OP_JAL):    o_imm_ctrl = IMM_J;
      default:                 o_imm_ctrl = IMM_I;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// rv32i multicycle fetch stage: owns PC and IR, runs the imem handshake.
// Define IMM_PREDECODE_EN to add the registered imm_ctrl output.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_start,
  input  logic         pc_we,
  input  logic [31:0]  pc_next,
  instr_fetch_if.master imem,
  output logic [31:0]  instr,
  output logic [31:0]  pc,
  output logic [31:0]  pc_old,
  output logic         instr_valid,
  output logic         fetch_busy,
`ifdef IMM_PREDECODE_EN
  output logic [2:0]   imm_ctrl,
`endif
  output logic         fetch_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pc_old;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic         r_req;
  logic         r_busy;
  logic         r_err;
  logic [7:0]   r_cnt;
  logic         w_aligned;
  logic         w_capture;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign w_capture = (r_state == S_WAIT) && imem.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_pc_old <= RESET_PC;
      r_instr  <= INSTR_NOP;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (pc_we) r_pc <= pc_next;
          if (fetch_start) begin
            // alignment is judged on the pc before any same-edge pc_we
            if (w_aligned) begin
              r_state <= S_WAIT;
              r_valid <= 1'b0;
              r_cnt   <= 8'd0;
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (imem.ready) begin
            r_instr  <= imem.rdata;
            r_pc_old <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_valid  <= 1'b1;
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_cnt == TMO_LAST) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ERR: begin
          if (pc_we) begin
            r_pc    <= pc_next;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IMM_PREDECODE_EN
  logic [2:0] w_imm;
  logic [2:0] r_imm;

  imm_predecode u_predecode (
    .i_opcode   (imem.rdata[6:0]),
    .o_imm_ctrl (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_imm <= IMM_I;
    else if (w_capture) r_imm <= w_imm;
  end

  assign imm_ctrl = r_imm;
`else
  logic w_unused;
  assign w_unused = w_capture;
`endif

  assign imem.req    = r_req;
  assign imem.addr   = r_pc;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_old      = r_pc_old;
  assign instr_valid = r_valid;
  assign fetch_busy  = r_busy;
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus corner sequences.
// Build with IMM_PREDECODE_EN defined to also check imm_ctrl.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_start;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_old;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;
`ifdef IMM_PREDECODE_EN
  logic [2:0]  imm_ctrl;
`endif

  int n_chk;
  int n_fail;

  instr_fetch_if ifc ();

  instr_fetch #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .imem        (ifc.master),
    .instr       (instr),
    .pc          (pc),
    .pc_old      (pc_old),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
`ifdef IMM_PREDECODE_EN
    .imm_ctrl    (imm_ctrl),
`endif
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [31:0] nxt;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] e_pc;
    logic [31:0] e_old;
    logic [2:0]  e_imm;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc_old"}, pc_old, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_req"}, 32'(ifc.req), 32'd0);
    chk({tag, "_busy"}, 32'(fetch_busy), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'd0);
`ifdef IMM_PREDECODE_EN
    chk({tag, "_imm"}, 32'(imm_ctrl), 32'd0);
`endif
  endtask

  task automatic run_vec(input int i, input vec_t v);
    if (v.load) begin
      pc_we   = 1'b1;
      pc_next = v.nxt;
      step();
      pc_we   = 1'b0;
    end
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int k = 0; k < v.dly; k++) begin
      chk($sformatf("v%0d_wait_req", i), 32'(ifc.req), 32'd1);
      chk($sformatf("v%0d_wait_addr", i), ifc.addr, v.e_old);
      chk($sformatf("v%0d_wait_busy", i), 32'(fetch_busy), 32'd1);
      step();
    end
    chk($sformatf("v%0d_req", i), 32'(ifc.req), 32'd1);
    chk($sformatf("v%0d_addr", i), ifc.addr, v.e_old);
    chk($sformatf("v%0d_valid_lo", i), 32'(instr_valid), 32'd0);
    ifc.ready = 1'b1;
    ifc.rdata = v.rdata;
    step();
    ifc.ready = 1'b0;
    ifc.rdata = 32'hDEAD_BEEF;
    chk($sformatf("v%0d_instr", i), instr, v.rdata);
    chk($sformatf("v%0d_pc", i), pc, v.e_pc);
    chk($sformatf("v%0d_pc_old", i), pc_old, v.e_old);
    chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
    chk($sformatf("v%0d_req_lo", i), 32'(ifc.req), 32'd0);
    chk($sformatf("v%0d_busy_lo", i), 32'(fetch_busy), 32'd0);
`ifdef IMM_PREDECODE_EN
    chk($sformatf("v%0d_imm", i), 32'(imm_ctrl), 32'(v.e_imm));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 32'h0, 32'h0050_0093, 0, 32'h4, 32'h0, 3'b000};
    vecs[1] = '{1'b0, 32'h0, 32'h0081_2023, 3, 32'h8, 32'h4, 3'b001};
    vecs[2] = '{1'b1, 32'h100, 32'hFE00_08E3, 1, 32'h104, 32'h100, 3'b011};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0040_006F, 0, 32'h0,
                32'hFFFF_FFFC, 3'b100};
    vecs[4] = '{1'b0, 32'h0, 32'h1234_5037, 2, 32'h4, 32'h0, 3'b010};
    vecs[5] = '{1'b0, 32'h0, 32'h0000_2083, 0, 32'h8, 32'h4, 3'b000};
    vecs[6] = '{1'b0, 32'h0, 32'h0000_0033, 1, 32'hC, 32'h8, 3'b000};

    rst_n       = 1'b0;
    fetch_start = 1'b0;
    pc_we       = 1'b0;
    pc_next     = 32'h0;
    ifc.ready   = 1'b0;
    ifc.rdata   = 32'h0;
    #23;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // ready/rdata noise while idle must not disturb the IR
    ifc.ready = 1'b1;
    ifc.rdata = 32'hAAAA_5555;
    step();
    step();
    ifc.ready = 1'b0;
    chk("idle_instr_stable", instr, 32'h0000_0033);
    chk("idle_pc_stable", pc, 32'hC);

    // misaligned pc
    pc_we   = 1'b1;
    pc_next = 32'h0000_0102;
    step();
    pc_we       = 1'b0;
    fetch_start = 1'b1;
    step();
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_req", 32'(ifc.req), 32'd0);
    step();
    step();
    fetch_start = 1'b0;
    chk("mis_req_held", 32'(ifc.req), 32'd0);
    chk("mis_err_held", 32'(fetch_err), 32'd1);
    chk("mis_pc", pc, 32'h102);
    pc_we   = 1'b1;
    pc_next = 32'h100;
    step();
    pc_we = 1'b0;
    chk("mis_clr_err", 32'(fetch_err), 32'd0);
    chk("mis_clr_pc", pc, 32'h100);

    // timeout: 4 request cycles, then error
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo_req%0d", k), 32'(ifc.req), 32'd1);
      chk($sformatf("tmo_err%0d", k), 32'(fetch_err), 32'd0);
      step();
    end
    chk("tmo_err", 32'(fetch_err), 32'd1);
    chk("tmo_req_lo", 32'(ifc.req), 32'd0);
    chk("tmo_instr", instr, 32'h0000_0033);
    chk("tmo_pc", pc, 32'h100);
    chk("tmo_pc_old", pc_old, 32'h8);
    chk("tmo_valid", 32'(instr_valid), 32'd0);
    pc_we   = 1'b1;
    pc_next = 32'h200;
    step();
    pc_we = 1'b0;
    chk("tmo_clr_err", 32'(fetch_err), 32'd0);

    // reset mid-WAIT, then a late ready
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("rw_req_hi", 32'(ifc.req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rw");
    @(negedge clk);
    rst_n     = 1'b1;
    ifc.ready = 1'b1;
    ifc.rdata = 32'h0040_006F;
    step();
    step();
    ifc.ready = 1'b0;
    chk_reset_vals("late");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
